// File: rtl/deserializer_ext.sv
// Narrow-beat to word deserializer with early termination and a
// valid/ready output stage whose backpressure reaches the input side.
module deserializer_ext #(
    parameter int DATA_W    = 16,
    parameter int IN_W      = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                             clk_i,
    input  logic                             srst_i,
    input  logic [IN_W-1:0]                  data_i,
    input  logic                             data_val_i,
    input  logic                             data_last_i,
    output logic                             data_ready_o,
    output logic [DATA_W-1:0]                deser_data_o,
    output logic                             deser_data_val_o,
    output logic [$clog2(DATA_W/IN_W+1)-1:0] deser_data_len_o,
    input  logic                             deser_data_ready_i
);

    localparam int BEATS = DATA_W / IN_W;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    if (DATA_W % IN_W != 0) begin : g_bad_width
        $error("deserializer_ext: DATA_W must be a multiple of IN_W");
    end

    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              complete;
    logic              consume;
    logic [DATA_W-1:0] word_next;

    // A pending word blocks new beats unless it is being consumed this cycle.
    assign data_ready_o = !srst_i && (!deser_data_val_o || deser_data_ready_i);
    assign accept       = data_val_i && data_ready_o;
    assign complete     = accept && (data_last_i || cnt == LAST_IDX);
    assign consume      = deser_data_val_o && deser_data_ready_i;

    // Beat 0 starts from a cleared word so unwritten slots of short frames read 0.
    always_comb begin
        word_next = (cnt == '0) ? '0 : deser_data_o;
        for (int i = 0; i < BEATS; i++) begin
            if (cnt == CNT_W'(i)) begin
                if (MSB_FIRST) begin
                    word_next[DATA_W-1-i*IN_W -: IN_W] = data_i;
                end else begin
                    word_next[i*IN_W +: IN_W] = data_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt              <= '0;
            deser_data_o     <= '0;
            deser_data_val_o <= 1'b0;
            deser_data_len_o <= '0;
        end else begin
            if (accept) begin
                deser_data_o <= word_next;
                cnt          <= complete ? '0 : cnt + 1'b1;
            end
            if (complete) begin
                deser_data_val_o <= 1'b1;
                deser_data_len_o <= cnt + 1'b1;
            end else if (consume) begin
                deser_data_val_o <= 1'b0;
            end
        end
    end

endmodule
